// File: rtl/sram_pkg.sv
// Shared definitions for the 1R1W SRAM: byte-lane width, clear-FSM states,
// and lane-count helper.
package sram_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic {
    CLEAR,
    READY
  } clearState_t;

  function automatic int unsigned laneCount(input int unsigned dataW);
    return dataW / LANE_W;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Post-reset clear engine: walks every word address once, strobing a zero
// write per cycle, then raises ready until the next reset.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset,
  output logic              clearWe,
  output logic [ADDR_W-1:0] clearAddr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clearState_t       state, stateNext;
  logic [ADDR_W-1:0] count, countNext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    if (state == CLEAR) begin
      if (count == LAST) stateNext = READY;
      else               countNext = count + 1'b1;
    end
  end

  assign clearWe   = (state == CLEAR);
  assign clearAddr = count;
  assign ready     = (state == READY);

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised 1-read/1-write synchronous SRAM with byte-lane write mask,
// registered read and optional read-during-write bypass.
// Define SRAM_INIT_CLEAR_EN to zero the array after reset before Ready rises.
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   WE,
  input  logic [ADDR_W-1:0]      WriteAddress,
  input  logic [DATA_W/8-1:0]    WriteMask,
  input  logic [DATA_W-1:0]      WriteBus,
  input  logic                   RE,
  input  logic [ADDR_W-1:0]      ReadAddress,
  output logic [DATA_W-1:0]      ReadBus,
  output logic                   ReadValid,
  output logic                   Ready
);

  localparam int unsigned   LANES   = laneCount(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              clearWe;
  logic [ADDR_W-1:0] clearAddr;
  logic              ready;

`ifdef SRAM_INIT_CLEAR_EN
  sram_clear_fsm #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) uClear (
    .clock    (clock),
    .reset    (reset),
    .clearWe  (clearWe),
    .clearAddr(clearAddr),
    .ready    (ready)
  );
`else
  assign clearWe   = 1'b0;
  assign clearAddr = '0;
  assign ready     = 1'b1;
`endif

  assign Ready = ready;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              userWrite, userRead, readInRange, collide;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [LANES-1:0]  memMask;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] oldWord, fwdWord;

  assign userWrite   = WE & ready & ({1'b0, WriteAddress} < DEPTH_L);
  assign userRead    = RE & ready;
  assign readInRange = ({1'b0, ReadAddress} < DEPTH_L);
  assign collide     = userWrite & (WriteAddress == ReadAddress);

  // Clear engine owns the write port while it runs; user writes are blocked by ready.
  always_comb begin
    memWe   = userWrite;
    memAddr = WriteAddress;
    memMask = WriteMask;
    memData = WriteBus;
    if (clearWe) begin
      memWe   = 1'b1;
      memAddr = clearAddr;
      memMask = '1;
      memData = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (memWe) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (memMask[b]) mem[memAddr][b*LANE_W +: LANE_W] <= memData[b*LANE_W +: LANE_W];
      end
    end
  end

  assign oldWord = mem[ReadAddress];

  always_comb begin
    fwdWord = oldWord;
    for (int unsigned b = 0; b < LANES; b++) begin
      if (WriteMask[b]) fwdWord[b*LANE_W +: LANE_W] = WriteBus[b*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ReadBus   <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= userRead;
      if (userRead) begin
        if (!readInRange)          ReadBus <= '0;
        else if (BYPASS && collide) ReadBus <= fwdWord;
        else                       ReadBus <= oldWord;
      end
    end
  end

endmodule
